// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 4-digit 7-segment scan bus: filters glitches, decodes each digit
// and republishes the left/right 2-digit values once all four digits have been captured.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter bit SEG_ACT_LOW    = 1'b1,
    parameter bit AN_ACT_LOW     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        clear,
    output logic [15:0] digit_code,
    output logic [7:0]  left_value,
    output logic [7:0]  right_value,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic        stale
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] SEG_IDLE = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_IDLE  = AN_ACT_LOW ? 4'hF : 4'h0;

    logic [6:0]    seg_m, seg_s, seg_n;
    logic [3:0]    an_m, an_s, an_n;
    logic [10:0]   cur, prev;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    cap_set, cap_bits, cap_an;
    logic [6:0]    cap_seg;
    logic [3:0]    dec;
    logic          capture, an_onehot, an_multi, publish;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:        decode = 4'd0;
            7'h06:        decode = 4'd1;
            7'h5B:        decode = 4'd2;
            7'h4F:        decode = 4'd3;
            7'h66:        decode = 4'd4;
            7'h6D:        decode = 4'd5;
            7'h7D:        decode = 4'd6;
            7'h07, 7'h27: decode = 4'd7;
            7'h7F:        decode = 4'd8;
            7'h6F, 7'h67: decode = 4'd9;
            7'h00:        decode = 4'hA;
            default:      decode = 4'hF;
        endcase
    endfunction

    // Blank and illegal digits contribute 0 to the reassembled value
    function automatic logic [7:0] dval(input logic [3:0] c);
        dval = (c <= 4'd9) ? {4'd0, c} : 8'd0;
    endfunction

    // Sync flops reset to the idle bus level so reset release looks like a blanking interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= SEG_IDLE;
            seg_s <= SEG_IDLE;
            an_m  <= AN_IDLE;
            an_s  <= AN_IDLE;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            an_m  <= an;
            an_s  <= an_m;
        end
    end

    assign seg_n = seg_s ^ {7{SEG_ACT_LOW}};
    assign an_n  = an_s ^ {4{AN_ACT_LOW}};
    assign cur   = {seg_n, an_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            stab_cnt <= '0;
        end else begin
            prev <= cur;
            if (clear || cur != prev)
                stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Count saturates past STABLE_CYCLES-1, so this fires once per scan window
    assign capture   = (stab_cnt == SW'(STABLE_CYCLES - 1)) && !clear;
    assign cap_seg   = prev[10:4];
    assign cap_an    = prev[3:0];
    assign an_onehot = (cap_an != 4'h0) && ((cap_an & (cap_an - 4'h1)) == 4'h0);
    assign an_multi  = (cap_an != 4'h0) && !an_onehot;
    assign cap_bits  = (capture && an_onehot) ? cap_an : 4'h0;
    assign dec       = decode(cap_seg);
    assign publish   = (cap_set == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_code  <= 16'hAAAA;
            left_value  <= '0;
            right_value <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            stale       <= 1'b0;
            cap_set     <= '0;
            tmo_cnt     <= '0;
        end else if (clear) begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            stale       <= 1'b0;
            cap_set     <= '0;
            tmo_cnt     <= '0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                // A capture on the publish cycle starts the next frame
                cap_set     <= cap_bits;
                left_value  <= dval(digit_code[15:12]) * 8'd10 + dval(digit_code[11:8]);
                right_value <= dval(digit_code[7:4]) * 8'd10 + dval(digit_code[3:0]);
                tmo_cnt     <= '0;
                stale       <= 1'b0;
            end else begin
                cap_set <= cap_set | cap_bits;
                if (tmo_cnt != TW'(TIMEOUT_CYCLES))
                    tmo_cnt <= tmo_cnt + 1'b1;
                else
                    stale <= 1'b1;
            end
            for (int k = 0; k < 4; k++)
                if (cap_bits[k])
                    digit_code[4*k +: 4] <= dec;
            if (cap_bits != 4'h0 && dec == 4'hF)
                seg_err <= 1'b1;
            if (capture && an_multi)
                an_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-scan vectors plus hand-written
// sequences for an_err, timeout/stale and mid-frame reset.
module tb_seg_scan_decoder;
    localparam int TMO = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        clear = 1'b0;
    logic [15:0] digit_code;
    logic [7:0]  left_value, right_value;
    logic        frame_valid, seg_err, an_err, stale;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    logic stale_at_fv = 1'b1;

    seg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(TMO), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clear(clear),
        .digit_code(digit_code), .left_value(left_value), .right_value(right_value),
        .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            stale_at_fv <= stale;
        end
    end

    typedef struct {
        logic [3:0][6:0] segs;   // index = digit position, [3] leftmost
        int              win;
        int              rots;
        bit              glitch;
        logic [15:0]     code;
        logic [7:0]      lv;
        logic [7:0]      rv;
        bit              serr;
        int              frames;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        seg = 7'h7F;
        an  = 4'hF;
        cycles(n);
    endtask

    task automatic scan_digit(input logic [6:0] pat, input int k, input int win, input bit glitch);
        an = ~(4'b0001 << k);
        if (glitch) begin
            seg = ~7'h49;
            cycles(5);
        end
        seg = ~pat;
        cycles(glitch ? win - 5 : win);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    initial begin
        int fv0;
        logic [3:0][6:0] p1234;
        logic [3:0][6:0] p5678;

        vecs[0] = '{segs: {7'h3F, 7'h6D, 7'h5B, 7'h07}, win: 1000, rots: 2, glitch: 0,
                    code: 16'h0527, lv: 8'd5, rv: 8'd27, serr: 0, frames: 2};
        vecs[1] = '{segs: {7'h6F, 7'h6F, 7'h6F, 7'h6F}, win: 40, rots: 1, glitch: 1,
                    code: 16'h9999, lv: 8'd99, rv: 8'd99, serr: 0, frames: 1};
        vecs[2] = '{segs: {7'h06, 7'h5B, 7'h4F, 7'h49}, win: 40, rots: 1, glitch: 0,
                    code: 16'h123F, lv: 8'd12, rv: 8'd30, serr: 1, frames: 1};
        vecs[3] = '{segs: {7'h27, 7'h67, 7'h00, 7'h66}, win: 40, rots: 1, glitch: 0,
                    code: 16'h79A4, lv: 8'd79, rv: 8'd4, serr: 0, frames: 1};
        vecs[4] = '{segs: {7'h7F, 7'h7D, 7'h06, 7'h3F}, win: 40, rots: 1, glitch: 0,
                    code: 16'h8610, lv: 8'd86, rv: 8'd10, serr: 0, frames: 1};
        p1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
        p5678 = {7'h6D, 7'h7D, 7'h07, 7'h7F};

        cycles(5);
        check("rst_digit_code", 32'(digit_code), 32'h0000AAAA);
        check("rst_left", 32'(left_value), 32'd0);
        check("rst_right", 32'(right_value), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_seg_err", 32'(seg_err), 32'd0);
        check("rst_an_err", 32'(an_err), 32'd0);
        check("rst_stale", 32'(stale), 32'd0);
        rst_n = 1'b1;
        blank(40);

        for (int v = 0; v < 5; v++) begin
            do_clear();
            blank(10);
            fv0 = fv_cnt;
            for (int r = 0; r < vecs[v].rots; r++)
                for (int k = 3; k >= 0; k--)
                    scan_digit(vecs[v].segs[k], k, vecs[v].win, vecs[v].glitch);
            blank(40);
            check($sformatf("v%0d_code", v), 32'(digit_code), 32'(vecs[v].code));
            check($sformatf("v%0d_left", v), 32'(left_value), 32'(vecs[v].lv));
            check($sformatf("v%0d_right", v), 32'(right_value), 32'(vecs[v].rv));
            check($sformatf("v%0d_seg_err", v), 32'(seg_err), 32'(vecs[v].serr));
            check($sformatf("v%0d_frames", v), 32'(fv_cnt - fv0), 32'(vecs[v].frames));
        end

        // Two digits selected at once: an_err only, nothing written, no frame
        do_clear();
        blank(10);
        fv0 = fv_cnt;
        seg = ~7'h06;
        an  = ~4'b0011;
        cycles(100);
        blank(20);
        check("an_err_set", 32'(an_err), 32'd1);
        check("an_err_code_held", 32'(digit_code), 32'h00008610);
        check("an_err_no_frame", 32'(fv_cnt - fv0), 32'd0);
        check("an_err_seg_err", 32'(seg_err), 32'd0);
        do_clear();
        cycles(2);
        check("clear_an_err", 32'(an_err), 32'd0);
        check("clear_code_held", 32'(digit_code), 32'h00008610);

        // Partial frame then silence -> stale; a full frame clears it on publish
        do_clear();
        blank(10);
        fv0 = fv_cnt;
        for (int k = 3; k >= 1; k--) scan_digit(p1234[k], k, 40, 0);
        blank(TMO + 50);
        check("stale_set", 32'(stale), 32'd1);
        check("stale_no_frame", 32'(fv_cnt - fv0), 32'd0);
        for (int k = 3; k >= 0; k--) scan_digit(p1234[k], k, 40, 0);
        blank(40);
        check("stale_frames", 32'(fv_cnt - fv0), 32'd1);
        check("stale_at_publish", 32'(stale_at_fv), 32'd0);
        check("stale_after", 32'(stale), 32'd0);
        check("stale_left", 32'(left_value), 32'd12);
        check("stale_right", 32'(right_value), 32'd34);

        // Reset mid-frame discards the partial capture set
        do_clear();
        blank(10);
        for (int k = 1; k >= 0; k--) scan_digit(p5678[k], k, 40, 0);
        rst_n = 1'b0;
        cycles(3);
        check("midrst_code", 32'(digit_code), 32'h0000AAAA);
        check("midrst_left", 32'(left_value), 32'd0);
        rst_n = 1'b1;
        blank(10);
        fv0 = fv_cnt;
        for (int k = 3; k >= 1; k--) scan_digit(p5678[k], k, 40, 0);
        check("midrst_no_early_frame", 32'(fv_cnt - fv0), 32'd0);
        scan_digit(p5678[0], 0, 40, 0);
        blank(40);
        check("midrst_frames", 32'(fv_cnt - fv0), 32'd1);
        check("midrst_code_after", 32'(digit_code), 32'h00005678);
        check("midrst_left_after", 32'(left_value), 32'd56);
        check("midrst_right_after", 32'(right_value), 32'd78);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
